sd_word_pack: RTL and testbench

- srdy/drdy width upsizer: packs `ratio` consecutive narrow consumer-side words into one wide producer-side word.
- Sits in front of wide-datapath srdy/drdy stages (FIFOs, ports).
- Supports early flush of a partial word through `c_last`.
- Both interfaces obey the standard srdy/drdy hold rules: srdy stays high and data stays stable until drdy.

---
 rtl/sd_pack_pkg.sv | 18 +
 rtl/sd_pack_oreg.sv | 29 ++
 rtl/sd_word_pack.sv | 65 ++++++
 tb/tb_sd_word_pack.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pack_pkg.sv
// Shared helpers for the srdy/drdy word packer: lane mask and index width.
package sd_pack_pkg;

  localparam int MAX_RATIO = 16;

  function automatic int idx_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Ones in lanes 0..idx, zeros above.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input int idx);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int l = 0; l < MAX_RATIO; l++) m[l] = (l <= idx);
    return m;
  endfunction

endpackage

// File: rtl/sd_pack_oreg.sv
// Single-entry srdy/drdy output holding register; reloads in the same cycle it drains.
module sd_pack_oreg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy
);

  assign in_rdy = !out_vld | out_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld & in_rdy) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/sd_word_pack.sv
// srdy/drdy width upsizer: packs ratio narrow words (or fewer, on c_last) into one wide word.
module sd_word_pack
  import sd_pack_pkg::*;
#(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c_srdy,
  output logic                   c_drdy,
  input  logic [width-1:0]       c_data,
  input  logic                   c_last,
  output logic                   p_srdy,
  input  logic                   p_drdy,
  output logic [width*ratio-1:0] p_data,
  output logic [ratio-1:0]       p_mask
);

  localparam int IDX_W = idx_width(ratio);
  localparam int DW    = width * ratio;

  logic [ratio-1:0][width-1:0] acc;
  logic [ratio-1:0][width-1:0] pack;
  logic [ratio-1:0]            mask;
  logic [IDX_W-1:0]            idx;
  logic                        c_xfer;
  logic                        done;

  assign c_xfer = c_srdy & c_drdy;
  assign done   = c_xfer & (c_last | (idx == IDX_W'(ratio - 1)));
  assign mask   = ratio'(lane_mask(int'(idx)));

  // Lanes at and above idx in acc are always zero, so only the current lane needs muxing.
  for (genvar l = 0; l < ratio; l++) begin : g_lane
    assign pack[l] = (IDX_W'(l) == idx) ? c_data : acc[l];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
    end else if (c_xfer) begin
      if (done) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc[idx] <= c_data;
        idx      <= idx + 1'b1;
      end
    end
  end

  sd_pack_oreg #(.W(DW + ratio)) u_oreg (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (done),
    .in_data  ({pack, mask}),
    .in_rdy   (c_drdy),
    .out_vld  (p_srdy),
    .out_data ({p_data, p_mask}),
    .out_rdy  (p_drdy)
  );

endmodule

// File: tb/tb_sd_word_pack.sv
// Self-checking bench for sd_word_pack: directed scenarios plus a scoreboarded random run.
module tb_sd_word_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_srdy = 1'b0;
  logic        c_last = 1'b0;
  logic [7:0]  c_data = '0;
  logic        p_drdy = 1'b0;
  logic        c_drdy;
  logic        p_srdy;
  logic [31:0] p_data;
  logic [3:0]  p_mask;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } word_t;

  word_t       sb[$];
  word_t       exp_w;
  word_t       new_w;
  logic [7:0]  macc[4];
  int          midx = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_mask;

  sd_word_pack #(.width(8), .ratio(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .c_last (c_last),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .p_mask (p_mask)
  );

  always #5 clk = ~clk;

  // Scoreboard, model and hold checker, sampled half a cycle before each active edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      midx = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        vectors++;
        if (p_srdy !== 1'b1 || p_data !== hold_data || p_mask !== hold_mask) begin
          miscompares++;
          $display("FAIL hold: got srdy=%b data=%h mask=%b want srdy=1 data=%h mask=%b",
                   p_srdy, p_data, p_mask, hold_data, hold_mask);
        end
      end
      if (p_srdy && p_drdy) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got data=%h mask=%b want no output", p_data, p_mask);
        end else begin
          exp_w = sb.pop_front();
          if (p_data !== exp_w.data || p_mask !== exp_w.mask) begin
            miscompares++;
            $display("FAIL sb_word: got data=%h mask=%b want data=%h mask=%b",
                     p_data, p_mask, exp_w.data, exp_w.mask);
          end
        end
      end
      hold_prev = p_srdy && !p_drdy;
      hold_data = p_data;
      hold_mask = p_mask;
      if (c_srdy && c_drdy) begin
        macc[midx] = c_data;
        if (midx == 3 || c_last) begin
          new_w.data = '0;
          for (int l = 0; l <= midx; l++) new_w.data[l*8 +: 8] = macc[l];
          new_w.mask = 4'((1 << (midx + 1)) - 1);
          sb.push_back(new_w);
          midx = 0;
        end else begin
          midx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic last);
    c_srdy = 1'b1;
    c_data = d;
    c_last = last;
    tick();
    c_srdy = 1'b0;
    c_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (p_srdy !== 1'b0 || p_mask !== 4'h0 || p_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got srdy=%b data=%h mask=%b want 0/0/0", p_srdy, p_data, p_mask);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    p_drdy = 1'b1;
    for (int i = 0; i < 4; i++) put(8'hA1 + 8'(i), 1'b0);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'hA4A3A2A1 || p_mask !== 4'hF) begin
      miscompares++;
      $display("FAIL full_word: got srdy=%b data=%h mask=%b want 1 a4a3a2a1 1111", p_srdy, p_data, p_mask);
    end
    tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_word_one_cycle: got srdy=%b want 0", p_srdy);
    end
  endtask

  task automatic test_partial();
    p_drdy = 1'b1;
    put(8'hB1, 1'b0);
    put(8'hB2, 1'b1);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'h0000B2B1 || p_mask !== 4'b0011) begin
      miscompares++;
      $display("FAIL partial: got srdy=%b data=%h mask=%b want 1 0000b2b1 0011", p_srdy, p_data, p_mask);
    end
    put(8'hC1, 1'b1);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'h000000C1 || p_mask !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_last: got srdy=%b data=%h mask=%b want 1 000000c1 0001", p_srdy, p_data, p_mask);
    end
    tick();
  endtask

  task automatic test_backpressure();
    p_drdy = 1'b0;
    for (int i = 0; i < 4; i++) put(8'hD1 + 8'(i), 1'b0);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'hD4D3D2D1) begin
      miscompares++;
      $display("FAIL bp_word: got srdy=%b data=%h want 1 d4d3d2d1", p_srdy, p_data);
    end
    c_srdy = 1'b1;
    c_data = 8'hE1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (c_drdy !== 1'b0 || p_srdy !== 1'b1 || p_data !== 32'hD4D3D2D1 || p_mask !== 4'hF) begin
        miscompares++;
        $display("FAIL bp_hold: got c_drdy=%b srdy=%b data=%h mask=%b want 0 1 d4d3d2d1 1111",
                 c_drdy, p_srdy, p_data, p_mask);
      end
      tick();
    end
    p_drdy = 1'b1;
    #1;
    vectors++;
    if (c_drdy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got c_drdy=%b want 1", c_drdy);
    end
    tick();
    c_srdy = 1'b0;
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got srdy=%b want 0", p_srdy);
    end
    for (int i = 1; i < 4; i++) put(8'hE1 + 8'(i), 1'b0);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'hE4E3E2E1) begin
      miscompares++;
      $display("FAIL bp_next: got srdy=%b data=%h want 1 e4e3e2e1", p_srdy, p_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    p_drdy = 1'b1;
    c_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_srdy = 1'b1;
      c_data = 8'h10 + 8'(i);
      tick();
      vectors++;
      if (p_srdy !== (i % 4 == 3)) begin
        miscompares++;
        $display("FAIL b2b_srdy[%0d]: got %b want %b", i, p_srdy, (i % 4 == 3));
      end
      if (i % 4 == 3) begin
        b = 8'h10 + 8'(i - 3);
        vectors++;
        if (p_data !== {b + 8'd3, b + 8'd2, b + 8'd1, b}) begin
          miscompares++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, p_data, {b + 8'd3, b + 8'd2, b + 8'd1, b});
        end
      end
    end
    c_srdy = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    p_drdy = 1'b1;
    put(8'h51, 1'b0);
    put(8'h52, 1'b0);
    reset = 1'b1;
    #1;
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_srdy: got %b want 0", p_srdy);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) put(8'h61 + 8'(i), 1'b0);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'h64636261 || p_mask !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_mid_after: got srdy=%b data=%h mask=%b want 1 64636261 1111", p_srdy, p_data, p_mask);
    end
    p_drdy = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) put(8'h71 + 8'(i), 1'b0);
    reset = 1'b1;
    #1;
    vectors++;
    if (p_srdy !== 1'b0 || p_mask !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_pend: got srdy=%b mask=%b want 0 0000", p_srdy, p_mask);
    end
    tick();
    reset = 1'b0;
    p_drdy = 1'b1;
    tick();
    vectors++;
    if (p_srdy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pend_quiet: got srdy=%b want 0", p_srdy);
    end
    for (int i = 0; i < 4; i++) put(8'h81 + 8'(i), 1'b0);
    vectors++;
    if (p_srdy !== 1'b1 || p_data !== 32'h84838281 || p_mask !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_pend_after: got srdy=%b data=%h mask=%b want 1 84838281 1111", p_srdy, p_data, p_mask);
    end
    tick();
  endtask

  task automatic test_random();
    logic xfer;
    xfer = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      p_drdy = (cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!(c_srdy && !xfer)) begin
        c_srdy = (cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        c_data = 8'($urandom);
        c_last = ($urandom_range(0, 4) == 0);
      end
      #1;
      xfer = c_srdy && c_drdy;
      tick();
    end
    c_srdy = 1'b0;
    c_last = 1'b0;
    p_drdy = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (sb.size() != 0 || p_srdy !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending, srdy=%b want 0 pending, srdy=0", sb.size(), p_srdy);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
